// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcodes, state enum and datapath select encodings
package mips_pkg;

  // Opcodes shared by the multicycle controller and the single-cycle decoder
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States that hold mem_req and wait on mem_ready
  function automatic logic is_mem_state(state_t s);
    return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
  endfunction

endpackage

// File: rtl/mips_mem_watchdog.sv
// rtl/mips_mem_watchdog.sv - stall counter that aborts memory accesses waiting too long
module mips_mem_watchdog #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TIMER_W        = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_mem_state,
  input  logic mem_ready,
  output logic timeout
);

  localparam logic [TIMER_W-1:0] LIMIT =
    (TIMEOUT_CYCLES > 0) ? TIMER_W'(TIMEOUT_CYCLES - 1) : '0;

  logic [TIMER_W-1:0] timer_q, timer_d;

  // Count only while stalled; any completion, abort or non-memory cycle
  // returns the counter to zero, so every memory state is entered cleared.
  always_comb begin
    timeout = 1'b0;
    timer_d = '0;
    if ((TIMEOUT_CYCLES > 0) && in_mem_state && !mem_ready) begin
      if (timer_q == LIMIT) begin
        timeout = 1'b1;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
  end

  // Timer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle MIPS main control FSM (optional bne: MIPS_MC_BNE_EN)
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TIMER_W        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       MemWrite,
  output logic       IorD,
  output logic       IRWrite,
  output logic       pc_en,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemToReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       illegal_op,
  output logic       mem_timeout,
  output logic [3:0] state_o
);

  state_t state_q, state_d;
  logic   in_mem;
  logic   timeout;
`ifdef MIPS_MC_BNE_EN
  logic   is_bne_q, is_bne_d;
`endif

  assign in_mem  = is_mem_state(state_q);
  assign state_o = state_q;

  mips_mem_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TIMER_W       (TIMER_W)
  ) u_watchdog (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_mem_state(in_mem),
    .mem_ready   (mem_ready),
    .timeout     (timeout)
  );

  // Next state and datapath controls; gated by rst_n so the memory
  // strobes drop the moment reset asserts rather than at the next edge.
  always_comb begin
    state_d     = state_q;
    mem_req     = 1'b0;
    MemWrite    = 1'b0;
    IorD        = 1'b0;
    IRWrite     = 1'b0;
    pc_en       = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    MemToReg    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_REGB;
    ALUOp       = ALUOP_ADD;
    PCSrc       = PCSRC_ALU;
    illegal_op  = 1'b0;
    mem_timeout = 1'b0;
`ifdef MIPS_MC_BNE_EN
    is_bne_d    = is_bne_q;
`endif
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          ALUSrcB = SRCB_FOUR;
          if (mem_ready) begin
            IRWrite = 1'b1;
            pc_en   = 1'b1;
            state_d = S_DECODE;
          end else if (timeout) begin
            mem_timeout = 1'b1;
            state_d     = S_FETCH;
          end
        end
        S_DECODE: begin
          // PC+4 is already in PC, so this computes the branch target into ALUOut
          ALUSrcB = SRCB_IMM_SH2;
          case (opcode)
            OP_RTYPE:     state_d = S_EXECUTE;
            OP_LW, OP_SW: state_d = S_MEMADR;
            OP_BEQ:       state_d = S_BRANCH;
`ifdef MIPS_MC_BNE_EN
            OP_BNE:       state_d = S_BRANCH;
`endif
            OP_ADDI:      state_d = S_ADDIEX;
            OP_J:         state_d = S_JUMP;
            default: begin
              illegal_op = 1'b1;
              state_d    = S_FETCH;
            end
          endcase
`ifdef MIPS_MC_BNE_EN
          is_bne_d = (opcode == OP_BNE);
`endif
        end
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
          state_d = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
        end
        S_MEMREAD: begin
          mem_req = 1'b1;
          IorD    = 1'b1;
          if (mem_ready) begin
            state_d = S_MEMWB;
          end else if (timeout) begin
            mem_timeout = 1'b1;
            state_d     = S_FETCH;
          end
        end
        S_MEMWB: begin
          RegWrite = 1'b1;
          MemToReg = 1'b1;
          state_d  = S_FETCH;
        end
        S_MEMWRITE: begin
          mem_req  = 1'b1;
          IorD     = 1'b1;
          MemWrite = 1'b1;
          if (mem_ready) begin
            state_d = S_FETCH;
          end else if (timeout) begin
            mem_timeout = 1'b1;
            state_d     = S_FETCH;
          end
        end
        S_EXECUTE: begin
          ALUSrcA = 1'b1;
          ALUOp   = ALUOP_FUNCT;
          state_d = S_ALUWB;
        end
        S_ALUWB: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
          state_d  = S_FETCH;
        end
        S_BRANCH: begin
          ALUSrcA = 1'b1;
          ALUOp   = ALUOP_SUB;
          PCSrc   = PCSRC_ALUOUT;
`ifdef MIPS_MC_BNE_EN
          pc_en   = zero ^ is_bne_q;
`else
          pc_en   = zero;
`endif
          state_d = S_FETCH;
        end
        S_ADDIEX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
          state_d = S_ADDIWB;
        end
        S_ADDIWB: begin
          RegWrite = 1'b1;
          state_d  = S_FETCH;
        end
        S_JUMP: begin
          PCSrc   = PCSRC_JUMP;
          pc_en   = 1'b1;
          state_d = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef MIPS_MC_BNE_EN
  // Branch polarity captured in DECODE for use in BRANCH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_bne_q <= 1'b0;
    end else begin
      is_bne_q <= is_bne_d;
    end
  end
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - vector, corner-case and randomized checks of the multicycle controller
module tb_mips_multicycle_ctrl;
  import mips_pkg::*;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero, mem_ready;
  logic       mem_req, MemWrite, IorD, IRWrite, pc_en, RegWrite, RegDst, MemToReg, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic       illegal_op, mem_timeout;
  logic [3:0] state_o;

  int checks = 0;
  int failures = 0;

  mips_multicycle_ctrl #(.TIMEOUT_CYCLES(TO), .TIMER_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite), .pc_en(pc_en),
    .RegWrite(RegWrite), .RegDst(RegDst), .MemToReg(MemToReg), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc), .illegal_op(illegal_op),
    .mem_timeout(mem_timeout), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic req, mw, iord, irw, pce, rw, rdst, m2r, sa;
    logic [1:0] sb, aop, pcs;
    logic ill, to;
  } outs_t;

  typedef struct {
    logic [5:0] op;
    logic       z;
    logic       r;
    outs_t      exp;
    string      name;
  } vec_t;

  vec_t tbl[$];

  function automatic outs_t mk(input state_t st, input bit req, mw, iord, irw, pce, rw, rdst, m2r, sa,
                               input bit [1:0] sb, aop, pcs, input bit ill, to);
    outs_t o;
    o.st = st; o.req = req; o.mw = mw; o.iord = iord; o.irw = irw; o.pce = pce;
    o.rw = rw; o.rdst = rdst; o.m2r = m2r; o.sa = sa; o.sb = sb; o.aop = aop; o.pcs = pcs;
    o.ill = ill; o.to = to;
    return o;
  endfunction

  // Expected control words per phase, straight from the behaviour table
  function automatic outs_t x_fetch(bit done, bit to);
    return mk(S_FETCH, 1, 0, 0, done, done, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0, to); endfunction
  function automatic outs_t x_decode(bit ill);
    return mk(S_DECODE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, ill, 0); endfunction
  function automatic outs_t x_memadr();
    return mk(S_MEMADR, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0, 0); endfunction
  function automatic outs_t x_memread(bit to);
    return mk(S_MEMREAD, 1, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, to); endfunction
  function automatic outs_t x_memwb();
    return mk(S_MEMWB, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0); endfunction
  function automatic outs_t x_memwrite(bit to);
    return mk(S_MEMWRITE, 1, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, to); endfunction
  function automatic outs_t x_execute();
    return mk(S_EXECUTE, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00, 0, 0); endfunction
  function automatic outs_t x_aluwb();
    return mk(S_ALUWB, 0, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0); endfunction
  function automatic outs_t x_branch(bit pce);
    return mk(S_BRANCH, 0, 0, 0, 0, pce, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 0, 0); endfunction
  function automatic outs_t x_addiex();
    return mk(S_ADDIEX, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0, 0); endfunction
  function automatic outs_t x_addiwb();
    return mk(S_ADDIWB, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0); endfunction
  function automatic outs_t x_jump();
    return mk(S_JUMP, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 0, 0); endfunction
  function automatic outs_t x_reset();
    return mk(S_FETCH, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0); endfunction

  function automatic outs_t sample();
    outs_t o;
    o.st = state_o; o.req = mem_req; o.mw = MemWrite; o.iord = IorD; o.irw = IRWrite;
    o.pce = pc_en; o.rw = RegWrite; o.rdst = RegDst; o.m2r = MemToReg; o.sa = ALUSrcA;
    o.sb = ALUSrcB; o.aop = ALUOp; o.pcs = PCSrc; o.ill = illegal_op; o.to = mem_timeout;
    return o;
  endfunction

  task automatic chk(input string name, input outs_t exp);
    outs_t got;
    got = sample();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got state=%0d ctl=%b, expected state=%0d ctl=%b",
               name, got.st, got[16:0], exp.st, exp[16:0]);
    end
  endtask

  // Apply inputs just after a rising edge, check on the falling edge
  task automatic cyc(input logic [5:0] op, input logic z, input logic r,
                     input outs_t exp, input string name);
    opcode = op; zero = z; mem_ready = r;
    @(negedge clk);
    chk(name, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [5:0] op, input logic z, input logic r,
                     input outs_t exp, input string name);
    vec_t v;
    v.op = op; v.z = z; v.r = r; v.exp = exp; v.name = name;
    tbl.push_back(v);
  endtask

  // Instruction-level reference: each opcode expands to its list of phases
  state_t m_q[$];
  int     m_wait;

  function automatic bit legal(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: return 1'b1;
`ifdef MIPS_MC_BNE_EN
      OP_BNE: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  task automatic load_seq(input logic [5:0] op);
    m_q.delete();
    m_q.push_back(S_DECODE);
    if (legal(op)) begin
      case (op)
        OP_RTYPE: begin m_q.push_back(S_EXECUTE); m_q.push_back(S_ALUWB); end
        OP_LW:    begin m_q.push_back(S_MEMADR); m_q.push_back(S_MEMREAD); m_q.push_back(S_MEMWB); end
        OP_SW:    begin m_q.push_back(S_MEMADR); m_q.push_back(S_MEMWRITE); end
        OP_ADDI:  begin m_q.push_back(S_ADDIEX); m_q.push_back(S_ADDIWB); end
        OP_J:     m_q.push_back(S_JUMP);
        default:  m_q.push_back(S_BRANCH);
      endcase
    end
    m_q.push_back(S_FETCH);
  endtask

  function automatic outs_t model_out(input state_t ph, input logic [5:0] op,
                                      input logic z, input logic r, input int wt);
    bit to;
    bit bne;
    to = !r && (wt == TO - 1);
`ifdef MIPS_MC_BNE_EN
    bne = (op == OP_BNE);
`else
    bne = 1'b0;
`endif
    case (ph)
      S_FETCH:    return x_fetch(r, to);
      S_DECODE:   return x_decode(!legal(op));
      S_MEMADR:   return x_memadr();
      S_MEMREAD:  return x_memread(to);
      S_MEMWB:    return x_memwb();
      S_MEMWRITE: return x_memwrite(to);
      S_EXECUTE:  return x_execute();
      S_ALUWB:    return x_aluwb();
      S_BRANCH:   return x_branch(z ^ bne);
      S_ADDIEX:   return x_addiex();
      S_ADDIWB:   return x_addiwb();
      default:    return x_jump();
    endcase
  endfunction

  task automatic model_advance(input logic [5:0] op, input logic r);
    state_t ph;
    ph = m_q[0];
    if (ph == S_FETCH || ph == S_MEMREAD || ph == S_MEMWRITE) begin
      if (r) begin
        m_wait = 0;
        if (ph == S_FETCH) load_seq(op);
        else void'(m_q.pop_front());
      end else if (m_wait == TO - 1) begin
        m_wait = 0;
        m_q.delete();
        m_q.push_back(S_FETCH);
      end else begin
        m_wait++;
      end
    end else begin
      void'(m_q.pop_front());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, required completion before 1ms");
    $fatal(1);
  end

  initial begin
    logic [5:0] rop;
    logic       rz, rr;
    int         mode;
    logic [5:0] ops [8];

    // Zero-wait instruction walk from reset
    add(OP_RTYPE, 0, 1, x_fetch(1, 0), "r_fetch");
    add(OP_RTYPE, 0, 1, x_decode(0),   "r_decode");
    add(OP_RTYPE, 0, 1, x_execute(),   "r_execute");
    add(OP_RTYPE, 0, 1, x_aluwb(),     "r_aluwb");
    add(OP_BEQ,   1, 1, x_fetch(1, 0), "beq1_fetch");
    add(OP_BEQ,   1, 1, x_decode(0),   "beq1_decode");
    add(OP_BEQ,   1, 1, x_branch(1),   "beq1_taken");
    add(OP_BEQ,   0, 1, x_fetch(1, 0), "beq0_fetch");
    add(OP_BEQ,   0, 1, x_decode(0),   "beq0_decode");
    add(OP_BEQ,   0, 1, x_branch(0),   "beq0_not_taken");
    add(OP_J,     0, 1, x_fetch(1, 0), "j_fetch");
    add(OP_J,     0, 1, x_decode(0),   "j_decode");
    add(OP_J,     0, 1, x_jump(),      "j_jump");
    add(OP_ADDI,  0, 1, x_fetch(1, 0), "addi_fetch");
    add(OP_ADDI,  0, 1, x_decode(0),   "addi_decode");
    add(OP_ADDI,  0, 1, x_addiex(),    "addi_ex");
    add(OP_ADDI,  0, 1, x_addiwb(),    "addi_wb");
    add(OP_SW,    0, 1, x_fetch(1, 0), "sw_fetch");
    add(OP_SW,    0, 1, x_decode(0),   "sw_decode");
    add(OP_SW,    0, 1, x_memadr(),    "sw_memadr");
    add(OP_SW,    0, 1, x_memwrite(0), "sw_memwrite");
    add(6'h3f,    0, 1, x_fetch(1, 0), "ill_fetch");
    add(6'h3f,    0, 1, x_decode(1),   "ill_decode");

    rst_n = 1'b0; opcode = '0; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", x_reset());
    @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (tbl[i]) cyc(tbl[i].op, tbl[i].z, tbl[i].r, tbl[i].exp, tbl[i].name);

    // lw with three wait cycles in MEMREAD: 8 cycles total
    cyc(OP_LW, 0, 1, x_fetch(1, 0), "lw_fetch");
    cyc(OP_LW, 0, 1, x_decode(0),   "lw_decode");
    cyc(OP_LW, 0, 1, x_memadr(),    "lw_memadr");
    for (int i = 0; i < 3; i++) cyc(OP_LW, 0, 0, x_memread(0), "lw_memread_wait");
    cyc(OP_LW, 0, 1, x_memread(0),  "lw_memread_done");
    cyc(OP_LW, 0, 1, x_memwb(),     "lw_memwb");

    // FETCH watchdog: abort on the 4th stalled cycle, then a completion on the 4th wins
    for (int i = 0; i < TO - 1; i++) cyc(OP_J, 0, 0, x_fetch(0, 0), "to_fetch_wait");
    cyc(OP_J, 0, 0, x_fetch(0, 1), "to_fetch_abort");
    for (int i = 0; i < TO - 1; i++) cyc(OP_J, 0, 0, x_fetch(0, 0), "to_refetch_wait");
    cyc(OP_J, 0, 1, x_fetch(1, 0), "to_ready_wins");
    cyc(OP_J, 0, 1, x_decode(0),   "to_j_decode");
    cyc(OP_J, 0, 1, x_jump(),      "to_j_jump");

    // Reset in the middle of a stalled store
    cyc(OP_SW, 0, 1, x_fetch(1, 0),   "rs_fetch");
    cyc(OP_SW, 0, 1, x_decode(0),     "rs_decode");
    cyc(OP_SW, 0, 1, x_memadr(),      "rs_memadr");
    cyc(OP_SW, 0, 0, x_memwrite(0),   "rs_memwrite_wait");
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_access", x_reset());
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(OP_BNE, 0, 0, x_fetch(0, 0), "fetch_after_reset");
    cyc(OP_BNE, 0, 1, x_fetch(1, 0), "bne_fetch");
`ifdef MIPS_MC_BNE_EN
    cyc(OP_BNE, 0, 1, x_decode(0),   "bne_decode");
    cyc(OP_BNE, 0, 1, x_branch(1),   "bne_taken");
`else
    cyc(OP_BNE, 0, 1, x_decode(1),   "bne_illegal");
`endif

    // Randomized instruction streams with random stalls against the phase-list model
    ops[0] = OP_RTYPE; ops[1] = OP_LW; ops[2] = OP_SW; ops[3] = OP_BEQ;
    ops[4] = OP_BNE;   ops[5] = OP_ADDI; ops[6] = OP_J; ops[7] = 6'h00;
    m_q.delete();
    m_q.push_back(S_FETCH);
    m_wait = 0;
    mode = 0;
    rop = OP_RTYPE;
    for (int c = 0; c < 1500; c++) begin
      if (m_q.size() == 1 && m_q[0] == S_FETCH && m_wait == 0) begin
        ops[7] = 6'($urandom_range(0, 63));
        rop  = ops[$urandom_range(0, 7)];
        mode = $urandom_range(0, 3);
      end
      rr = (mode == 0) ? 1'b1 : (mode == 3) ? 1'b0 : 1'($urandom_range(0, 1));
      rz = 1'($urandom_range(0, 1));
      opcode = rop; zero = rz; mem_ready = rr;
      @(negedge clk);
      chk("random", model_out(m_q[0], rop, rz, rr, m_wait));
      model_advance(rop, rr);
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
